pkt_stat_gen: RTL and testbench



---
 rtl/pkt_stat_gen_if.sv | 13 +
 rtl/pkt_stat_gen.sv | 244 ++++++++++++++++++++++++
 tb/tb_pkt_stat_gen.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_stat_gen_if.sv
// Packet stream bundle into pkt_stat_gen: master drives frames, slave observes them.
interface pkt_stat_gen_if;
    logic [3:0]  port_id;
    logic        pkt_valid;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [1:0]  pkt_empty;
    logic        pkt_err;
    logic [31:0] pkt_data;

    modport master (output port_id, pkt_valid, pkt_sop, pkt_eop, pkt_empty, pkt_err, pkt_data);
    modport slave  (input  port_id, pkt_valid, pkt_sop, pkt_eop, pkt_empty, pkt_err, pkt_data);
endinterface

// File: rtl/pkt_stat_gen.sv
// Per-packet statistics generator: classifies frames and publishes a held record via a stat_chk level.
// Optional inter-packet-gap counter in vector slot 2 is enabled by defining STAT_GEN_IPG_EN.
module pkt_stat_gen #(
    parameter int unsigned BIT_WIDTH       = 64,
    parameter int unsigned VEC_WIDTH_INDEX = 4,
    parameter int unsigned VEC_WIDTH_VALUE = 32,
    parameter int unsigned VEC_NUM         = 16,
    parameter int unsigned VEC_WIDTH_TOTAL = (VEC_WIDTH_INDEX + VEC_WIDTH_VALUE) * VEC_NUM,
    parameter int unsigned MAX_LEN         = 1518,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    pkt_stat_gen_if.slave              pkt_i,
    output logic                       stat_chk_o,
    output logic [3:0]                 stat_base_addr_o,
    output logic [BIT_WIDTH-1:0]       stat_bit_o,
    output logic [VEC_WIDTH_TOTAL-1:0] stat_vec_o,
    output logic [15:0]                lost_cnt_o,
    output logic                       busy_o
);
    localparam int unsigned SLOT_W   = VEC_WIDTH_INDEX + VEC_WIDTH_VALUE;
    localparam int unsigned HIGH_CYC = HOLD_CYCLES / 2;
    localparam int unsigned LOW_CYC  = HOLD_CYCLES - HIGH_CYC;
    localparam int unsigned HCNT_W   = $clog2(HOLD_CYCLES + 1);

    typedef enum logic       {S_IDLE, S_IN_PKT} parse_e;
    typedef enum logic [1:0] {P_IDLE, P_HIGH, P_LOW} pub_e;

    parse_e      parse_q;
    logic [15:0] words_q;
    logic [47:0] da_q;
    logic [3:0]  port_q;
    logic        framing_q;

    pub_e                       pub_q;
    logic [HCNT_W-1:0]          hcnt_q;
    logic                       pend_q;
    logic [3:0]                 pend_port_q;
    logic [BIT_WIDTH-1:0]       pend_bit_q;
    logic [VEC_WIDTH_TOTAL-1:0] pend_vec_q;
    logic                       lost_q;
    logic [15:0]                lost_cnt_q;
    logic                       busy_q;
    logic                       chk_q;
    logic [3:0]                 base_q;
    logic [BIT_WIDTH-1:0]       bit_q;
    logic [VEC_WIDTH_TOTAL-1:0] vec_q;

    logic idle_start_c, abort_c, tail_c, stray_c, eop_done_c, done_c;
    logic free_c, accept_c, drop_c, busy_d;
    logic [15:0] words_inc_c, rec_words_c, rec_len_c, rec_len18_c;
    logic [17:0] len_raw_c;
    logic [47:0] rec_da_c;
    logic [3:0]  rec_port_c;
    logic        rec_err_c, rec_bcast_c, rec_mcast_c;
    logic [31:0] rec_ipg_c;
    logic [BIT_WIDTH-1:0]       rec_bit_c, pub_bit_c;
    logic [VEC_WIDTH_TOTAL-1:0] rec_vec_c;

    // Word classification; a sop+eop word inside a frame is treated as its last word.
    assign idle_start_c = pkt_i.pkt_valid & pkt_i.pkt_sop & (parse_q == S_IDLE);
    assign abort_c      = pkt_i.pkt_valid & pkt_i.pkt_sop & ~pkt_i.pkt_eop & (parse_q == S_IN_PKT);
    assign tail_c       = pkt_i.pkt_valid & ~abort_c & (parse_q == S_IN_PKT);
    assign stray_c      = pkt_i.pkt_valid & ~pkt_i.pkt_sop & (parse_q == S_IDLE);
    assign eop_done_c   = (idle_start_c | tail_c) & pkt_i.pkt_eop;
    assign done_c       = eop_done_c | abort_c;

    // Record built from the completing frame
    always_comb begin
        words_inc_c = (words_q == 16'hffff) ? words_q : words_q + 16'd1;
        rec_words_c = words_inc_c;
        rec_da_c    = da_q;
        rec_port_c  = port_q;
        rec_err_c   = pkt_i.pkt_err;
        if (idle_start_c) begin
            rec_words_c = 16'd1;
            rec_da_c    = {pkt_i.pkt_data, 16'h0};
            rec_port_c  = pkt_i.port_id;
        end else if (abort_c) begin
            rec_words_c = words_q;
            rec_err_c   = 1'b1;
        end else if (words_q == 16'd1) begin
            rec_da_c[15:0] = pkt_i.pkt_data[31:16];
        end
        len_raw_c   = {rec_words_c, 2'b00} - {16'h0, (abort_c ? 2'b00 : pkt_i.pkt_empty)};
        rec_len_c   = (|len_raw_c[17:16]) ? 16'hffff : len_raw_c[15:0];
        rec_len18_c = (rec_len_c >= 16'd18) ? rec_len_c - 16'd18 : 16'd0;
        rec_bcast_c = &rec_da_c;
        rec_mcast_c = rec_da_c[40] & ~rec_bcast_c;

        rec_bit_c     = '0;
        rec_bit_c[0]  = 1'b1;
        rec_bit_c[1]  = ~rec_err_c & (rec_len_c >= 16'd64) & (rec_len_c <= 16'(MAX_LEN));
        rec_bit_c[2]  = rec_err_c;
        rec_bit_c[3]  = ~rec_bcast_c & ~rec_mcast_c;
        rec_bit_c[4]  = rec_mcast_c;
        rec_bit_c[5]  = rec_bcast_c;
        rec_bit_c[6]  = rec_len_c < 16'd64;
        rec_bit_c[7]  = rec_len_c == 16'd64;
        rec_bit_c[8]  = (rec_len_c >= 16'd65) & (rec_len_c <= 16'd127);
        rec_bit_c[9]  = (rec_len_c >= 16'd128) & (rec_len_c <= 16'd255);
        rec_bit_c[10] = (rec_len_c >= 16'd256) & (rec_len_c <= 16'd511);
        rec_bit_c[11] = (rec_len_c >= 16'd512) & (rec_len_c <= 16'd1023);
        rec_bit_c[12] = (rec_len_c >= 16'd1024) & (rec_len_c <= 16'(MAX_LEN));
        rec_bit_c[13] = rec_len_c > 16'(MAX_LEN);
        rec_bit_c[14] = (rec_len_c < 16'd64) & rec_err_c;
        rec_bit_c[15] = abort_c | framing_q;

        rec_vec_c = '0;
        rec_vec_c[0 +: SLOT_W]        = {VEC_WIDTH_INDEX'(0), VEC_WIDTH_VALUE'(rec_len_c)};
        rec_vec_c[SLOT_W +: SLOT_W]   = {VEC_WIDTH_INDEX'(1), VEC_WIDTH_VALUE'(rec_len18_c)};
        rec_vec_c[2*SLOT_W +: SLOT_W] = {VEC_WIDTH_INDEX'(2), VEC_WIDTH_VALUE'(rec_ipg_c)};
    end

    // Parser FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parse_q   <= S_IDLE;
            words_q   <= '0;
            da_q      <= '0;
            port_q    <= '0;
            framing_q <= 1'b0;
        end else begin
            if (stray_c)     framing_q <= 1'b1;
            else if (done_c) framing_q <= 1'b0;
            if (idle_start_c | abort_c) begin
                words_q <= 16'd1;
                da_q    <= {pkt_i.pkt_data, 16'h0};
                port_q  <= pkt_i.port_id;
                parse_q <= (idle_start_c & pkt_i.pkt_eop) ? S_IDLE : S_IN_PKT;
            end else if (tail_c) begin
                words_q <= words_inc_c;
                da_q    <= rec_da_c;
                if (pkt_i.pkt_eop) parse_q <= S_IDLE;
            end
        end
    end

`ifdef STAT_GEN_IPG_EN
    logic [31:0] ipg_cnt_q, ipg_frame_q, ipg_now_c;
    logic        ipg_run_q;

    // Gap restarts after every eop; before the first eop there is no gap to report.
    assign ipg_now_c = ipg_run_q ? ipg_cnt_q : 32'd0;
    assign rec_ipg_c = idle_start_c ? ipg_now_c : ipg_frame_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ipg_cnt_q   <= '0;
            ipg_frame_q <= '0;
            ipg_run_q   <= 1'b0;
        end else begin
            if (eop_done_c) begin
                ipg_cnt_q <= '0;
                ipg_run_q <= 1'b1;
            end else if (ipg_cnt_q != 32'hffff_ffff) begin
                ipg_cnt_q <= ipg_cnt_q + 32'd1;
            end
            if (idle_start_c)  ipg_frame_q <= ipg_now_c;
            else if (abort_c)  ipg_frame_q <= '0;
        end
    end
`else
    assign rec_ipg_c = 32'd0;
`endif

    // Pending slot is freed on the same edge the publish FSM takes it.
    assign free_c   = pend_q & (pub_q == P_IDLE);
    assign accept_c = done_c & (~pend_q | free_c);
    assign drop_c   = done_c & ~accept_c;
    assign busy_d   = accept_c | (pend_q & ~free_c) |
                      ((pub_q == P_IDLE) ? pend_q
                                         : ~((pub_q == P_LOW) && (hcnt_q == HCNT_W'(LOW_CYC - 1))));

    always_comb begin
        pub_bit_c     = pend_bit_q;
        pub_bit_c[63] = pend_bit_q[63] | lost_q;
    end

    // Pending buffer and publish FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pub_q       <= P_IDLE;
            hcnt_q      <= '0;
            pend_q      <= 1'b0;
            pend_port_q <= '0;
            pend_bit_q  <= '0;
            pend_vec_q  <= '0;
            lost_q      <= 1'b0;
            lost_cnt_q  <= '0;
            busy_q      <= 1'b0;
            chk_q       <= 1'b0;
            base_q      <= '0;
            bit_q       <= '0;
            vec_q       <= '0;
        end else begin
            busy_q <= busy_d;
            if (accept_c) begin
                pend_q      <= 1'b1;
                pend_port_q <= rec_port_c;
                pend_bit_q  <= rec_bit_c;
                pend_vec_q  <= rec_vec_c;
            end else if (free_c) begin
                pend_q <= 1'b0;
            end
            if (drop_c) begin
                lost_q <= 1'b1;
                if (lost_cnt_q != 16'hffff) lost_cnt_q <= lost_cnt_q + 16'd1;
            end
            case (pub_q)
                P_IDLE: if (pend_q) begin
                    base_q <= pend_port_q;
                    bit_q  <= pub_bit_c;
                    vec_q  <= pend_vec_q;
                    lost_q <= 1'b0;
                    chk_q  <= 1'b1;
                    hcnt_q <= '0;
                    pub_q  <= P_HIGH;
                end
                P_HIGH: if (hcnt_q == HCNT_W'(HIGH_CYC - 1)) begin
                    chk_q  <= 1'b0;
                    hcnt_q <= '0;
                    pub_q  <= P_LOW;
                end else begin
                    hcnt_q <= hcnt_q + HCNT_W'(1);
                end
                P_LOW: if (hcnt_q == HCNT_W'(LOW_CYC - 1)) begin
                    pub_q <= P_IDLE;
                end else begin
                    hcnt_q <= hcnt_q + HCNT_W'(1);
                end
                default: pub_q <= P_IDLE;
            endcase
        end
    end

    assign stat_chk_o       = chk_q;
    assign stat_base_addr_o = base_q;
    assign stat_bit_o       = bit_q;
    assign stat_vec_o       = vec_q;
    assign lost_cnt_o       = lost_cnt_q;
    assign busy_o           = busy_q;
endmodule

// File: tb/tb_pkt_stat_gen.sv
// Scoreboard bench for pkt_stat_gen: expected records queued at stimulus, checked on each stat_chk rise.
`timescale 1ns/1ps
module tb_pkt_stat_gen;
    localparam int unsigned VW = 576;

    logic          clk = 1'b0;
    logic          rst;
    logic          stat_chk;
    logic [3:0]    stat_base_addr;
    logic [63:0]   stat_bit;
    logic [VW-1:0] stat_vec;
    logic [15:0]   lost_cnt;
    logic          busy;

    always #5 clk = ~clk;

    pkt_stat_gen_if pkt_if();

    pkt_stat_gen dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_i            (pkt_if),
        .stat_chk_o       (stat_chk),
        .stat_base_addr_o (stat_base_addr),
        .stat_bit_o       (stat_bit),
        .stat_vec_o       (stat_vec),
        .lost_cnt_o       (lost_cnt),
        .busy_o           (busy)
    );

    typedef struct {
        logic [3:0]  base;
        logic [63:0] bits;
        int          len;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [VW-1:0] mon_vec, mon_want;
    logic          chk_d;
    int            checks   = 0;
    int            failures = 0;

    // Reference classification; cls 0=unicast 1=multicast 2=broadcast
    function automatic logic [63:0] model_bits(int len, bit err, bit frm, int cls, bit lost);
        logic [63:0] b = '0;
        b[0]       = 1'b1;
        b[2]       = err;
        b[15]      = frm;
        b[63]      = lost;
        b[3 + cls] = 1'b1;
        if (len < 64) begin
            b[6]  = 1'b1;
            b[14] = err;
        end
        else if (len == 64)  b[7]  = 1'b1;
        else if (len < 128)  b[8]  = 1'b1;
        else if (len < 256)  b[9]  = 1'b1;
        else if (len < 512)  b[10] = 1'b1;
        else if (len < 1024) b[11] = 1'b1;
        else if (len <= 1518) b[12] = 1'b1;
        else                 b[13] = 1'b1;
        b[1] = !err && len >= 64 && len <= 1518;
        return b;
    endfunction

    function automatic logic [VW-1:0] model_vec(int len);
        logic [VW-1:0] v = '0;
        v[35:0]   = {4'd0, 32'(len)};
        v[71:36]  = {4'd1, 32'(len > 18 ? len - 18 : 0)};
        v[107:72] = {4'd2, 32'd0};
        return v;
    endfunction

    // Scoreboard: each stat_chk rising level pops and checks one record
    always @(negedge clk) begin
        if (rst) begin
            chk_d <= 1'b0;
        end else begin
            chk_d <= stat_chk;
            if (stat_chk && !chk_d) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_publish base=%h bits=%h", stat_base_addr, stat_bit);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_vec  = stat_vec;
                    mon_want = model_vec(mon_e.len);
`ifdef STAT_GEN_IPG_EN
                    mon_vec[103:72] = 32'd0;
`endif
                    checks++;
                    if (stat_bit !== mon_e.bits) begin
                        failures++;
                        $display("FAIL rec_bits got=%h want=%h", stat_bit, mon_e.bits);
                    end
                    checks++;
                    if (stat_base_addr !== mon_e.base) begin
                        failures++;
                        $display("FAIL rec_base got=%h want=%h", stat_base_addr, mon_e.base);
                    end
                    checks++;
                    if (mon_vec !== mon_want) begin
                        failures++;
                        $display("FAIL rec_vec got=%h want=%h", mon_vec, mon_want);
                    end
                end
            end
        end
    end

    task automatic drive_idle;
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_sop   = 1'b0;
        pkt_if.pkt_eop   = 1'b0;
        pkt_if.pkt_empty = 2'd0;
        pkt_if.pkt_err   = 1'b0;
        pkt_if.port_id   = 4'h0;
        pkt_if.pkt_data  = 32'h0;
    endtask

    // One frame on consecutive cycles; err and port_id are scrambled where they must be ignored
    task automatic send_frame(input int nwords, input logic [1:0] empty, input logic err,
                              input logic [47:0] da, input logic [3:0] pid);
        for (int i = 0; i < nwords; i++) begin
            @(posedge clk); #1;
            pkt_if.pkt_valid = 1'b1;
            pkt_if.pkt_sop   = (i == 0);
            pkt_if.pkt_eop   = (i == nwords - 1);
            pkt_if.pkt_empty = empty;
            pkt_if.pkt_err   = (i == nwords - 1) ? err : 1'b1;
            pkt_if.port_id   = (i == 0) ? pid : ~pid;
            pkt_if.pkt_data  = (i == 0) ? da[47:16] : (i == 1) ? {da[15:0], 16'($urandom)} : $urandom;
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (stat_chk !== 1'b0) begin failures++; $display("FAIL rst_chk got=%b want=0", stat_chk); end
        checks++; if (stat_base_addr !== 4'h0) begin failures++; $display("FAIL rst_base got=%h want=0", stat_base_addr); end
        checks++; if (stat_bit !== 64'h0) begin failures++; $display("FAIL rst_bits got=%h want=0", stat_bit); end
        checks++; if (stat_vec !== '0) begin failures++; $display("FAIL rst_vec got=%h want=0", stat_vec); end
        checks++; if (lost_cnt !== 16'h0) begin failures++; $display("FAIL rst_lost got=%h want=0", lost_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int hi;
        exp_q.push_back('{base: 4'h3, bits: model_bits(64, 0, 0, 2, 0), len: 64});
        send_frame(16, 2'd0, 1'b0, 48'hffff_ffff_ffff, 4'h3);
        @(negedge clk);
        checks++; if (stat_chk !== 1'b0) begin failures++; $display("FAIL chk_t1 got=%b want=0", stat_chk); end
        @(negedge clk);
        checks++; if (stat_chk !== 1'b1) begin failures++; $display("FAIL chk_t2 got=%b want=1", stat_chk); end
        hi = 0;
        while (stat_chk === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        checks++; if (hi != 4) begin failures++; $display("FAIL chk_high_cycles got=%0d want=4", hi); end
        for (int i = 0; i < 100 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_basic busy=%b left=%0d want busy=0 left=0", busy, exp_q.size()); end
    endtask

    task automatic test_oversize_mcast;
        exp_q.push_back('{base: 4'h5, bits: model_bits(1519, 0, 0, 1, 0), len: 1519});
        send_frame(380, 2'd1, 1'b0, 48'h0100_5e00_0001, 4'h5);
        for (int i = 0; i < 100 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_oversize busy=%b left=%0d want busy=0 left=0", busy, exp_q.size()); end
    endtask

    task automatic test_err_runt;
        exp_q.push_back('{base: 4'h4, bits: model_bits(40, 1, 0, 0, 0), len: 40});
        send_frame(10, 2'd0, 1'b1, 48'h0011_2233_4455, 4'h4);
        for (int i = 0; i < 100 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_err busy=%b left=%0d want busy=0 left=0", busy, exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back('{base: 4'h1, bits: model_bits(4, 0, 0, 0, 0), len: 4});
        exp_q.push_back('{base: 4'h2, bits: model_bits(4, 0, 0, 0, 1), len: 4});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            pkt_if.pkt_valid = 1'b1;
            pkt_if.pkt_sop   = 1'b1;
            pkt_if.pkt_eop   = 1'b1;
            pkt_if.pkt_empty = 2'd0;
            pkt_if.pkt_err   = 1'b0;
            pkt_if.port_id   = 4'(i + 1);
            pkt_if.pkt_data  = 32'h0200_0000 | 32'(i);
        end
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 100 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_b2b busy=%b left=%0d want busy=0 left=0", busy, exp_q.size()); end
        checks++; if (lost_cnt !== 16'd1) begin failures++; $display("FAIL lost_cnt_b2b got=%0d want=1", lost_cnt); end
    endtask

    task automatic test_abort;
        exp_q.push_back('{base: 4'h6, bits: model_bits(20, 1, 1, 0, 0), len: 20});
        exp_q.push_back('{base: 4'h7, bits: model_bits(72, 0, 0, 2, 0), len: 72});
        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            pkt_if.pkt_valid = 1'b1;
            pkt_if.pkt_sop   = (i == 0 || i == 5);
            pkt_if.pkt_eop   = (i == 22);
            pkt_if.pkt_empty = 2'd0;
            pkt_if.pkt_err   = (i != 22);
            pkt_if.port_id   = (i == 0) ? 4'h6 : (i == 5) ? 4'h7 : 4'hf;
            pkt_if.pkt_data  = (i == 0) ? 32'h0a0b_0c0d : (i == 1) ? 32'h0e0f_1234 :
                               (i == 5) ? 32'hffff_ffff : (i == 6) ? 32'hffff_0000 : $urandom;
        end
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 100 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_abort busy=%b left=%0d want busy=0 left=0", busy, exp_q.size()); end
    endtask

    task automatic test_framing;
        exp_q.push_back('{base: 4'hb, bits: model_bits(64, 0, 1, 0, 0), len: 64});
        exp_q.push_back('{base: 4'hc, bits: model_bits(65, 0, 0, 1, 0), len: 65});
        @(posedge clk); #1;
        pkt_if.pkt_valid = 1'b1;
        pkt_if.pkt_eop   = 1'b1;
        pkt_if.pkt_data  = 32'hdead_beef;
        @(posedge clk); #1;
        drive_idle();
        send_frame(16, 2'd0, 1'b0, 48'h0200_0000_0001, 4'hb);
        send_frame(17, 2'd3, 1'b0, 48'h0300_0000_0002, 4'hc);
        for (int i = 0; i < 100 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_framing busy=%b left=%0d want busy=0 left=0", busy, exp_q.size()); end
    endtask

    task automatic test_reset_midflight;
        exp_q.push_back('{base: 4'h9, bits: model_bits(4, 0, 0, 0, 0), len: 4});
        send_frame(1, 2'd0, 1'b0, 48'h0400_0000_0000, 4'h9);
        @(negedge clk);
        @(negedge clk);
        checks++; if (stat_chk !== 1'b1) begin failures++; $display("FAIL mid_chk_high got=%b want=1", stat_chk); end
        @(posedge clk); #1;
        pkt_if.pkt_valid = 1'b1;
        pkt_if.pkt_sop   = 1'b1;
        pkt_if.port_id   = 4'h8;
        pkt_if.pkt_data  = 32'hffff_ffff;
        @(posedge clk); #1;
        pkt_if.pkt_sop   = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (stat_chk !== 1'b0) begin failures++; $display("FAIL mid_rst_chk got=%b want=0", stat_chk); end
        checks++; if (stat_bit !== 64'h0 || stat_base_addr !== 4'h0) begin failures++; $display("FAIL mid_rst_rec got=%h/%h want=0/0", stat_bit, stat_base_addr); end
        checks++; if (stat_vec !== '0) begin failures++; $display("FAIL mid_rst_vec got=%h want=0", stat_vec); end
        checks++; if (lost_cnt !== 16'h0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_cnt got=%h/%b want=0/0", lost_cnt, busy); end
        exp_q.delete();
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{base: 4'ha, bits: model_bits(64, 0, 0, 0, 0), len: 64});
        send_frame(16, 2'd0, 1'b0, 48'h0200_1122_3344, 4'ha);
        for (int i = 0; i < 100 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_after_rst busy=%b left=%0d want busy=0 left=0", busy, exp_q.size()); end
        checks++; if (lost_cnt !== 16'h0) begin failures++; $display("FAIL lost_after_rst got=%0d want=0", lost_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_oversize_mcast();
        test_err_runt();
        test_back_to_back();
        test_abort();
        test_framing();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
